// File: rtl/map_access_arbiter_if.sv
// Requester and map-RAM signal bundle for map_access_arbiter.
// master = requesters plus map RAM, slave = the arbiter.
interface map_access_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   we_in;
  logic [5*NUM_REQ-1:0] x_in;
  logic [5*NUM_REQ-1:0] y_in;
  logic [3*NUM_REQ-1:0] wdata_in;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   done;
  logic [2:0]           rdata;
  logic                 busy;
  logic [4:0]           ram_x;
  logic [4:0]           ram_y;
  logic                 ram_we;
  logic [2:0]           ram_wdata;
  logic [2:0]           ram_rdata;

  modport master (
    output req, we_in, x_in, y_in, wdata_in, ram_rdata,
    input  grant, done, rdata, busy, ram_x, ram_y, ram_we, ram_wdata
  );

  modport slave (
    input  req, we_in, x_in, y_in, wdata_in, ram_rdata,
    output grant, done, rdata, busy, ram_x, ram_y, ram_we, ram_wdata
  );
endinterface

// File: rtl/map_access_arbiter.sv
// Round-robin arbiter granting pacman/ghost requesters 4-cycle access to the map RAM.
// Optional macro PACMAN_PRIORITY_EN: requester 0 always wins, ghosts round-robin behind it.
module map_access_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAP_W   = 24,
  parameter int unsigned MAP_H   = 24
) (
  input logic clock,
  input logic reset,
  map_access_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0]  WALL  = 3'b011;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_next;

  logic [IDX_W-1:0]   last_winner;
  logic [IDX_W-1:0]   win;
  logic               found;
  int unsigned        cand;
  logic [NUM_REQ-1:0] grant_q;
  logic [2:0]         rdata_q;
  logic               r_we, r_oob;
  logic [4:0]         r_x, r_y;
  logic [2:0]         r_wdata;
  logic               sel_we;
  logic [4:0]         sel_x, sel_y;
  logic [2:0]         sel_wdata;

`ifdef PACMAN_PRIORITY_EN
  logic [IDX_W-1:0] last_ghost;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    if (bus.req[0]) begin
      found = 1'b1;
    end else begin
      // ghost ring 1..NUM_REQ-1 resumes after the last ghost served
      for (int unsigned k = 1; k < NUM_REQ; k++) begin
        cand = 1 + ((32'(last_ghost) + k - 1) % (NUM_REQ - 1));
        if (!found && bus.req[IDX_W'(cand)]) begin
          found = 1'b1;
          win   = IDX_W'(cand);
        end
      end
    end
  end
`else
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(last_winner) + k) % NUM_REQ;
      if (!found && bus.req[IDX_W'(cand)]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
  end
`endif

  always_comb begin
    sel_we    = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == IDX_W'(i)) begin
        sel_we    = bus.we_in[i];
        sel_x     = bus.x_in[5*i +: 5];
        sel_y     = bus.y_in[5*i +: 5];
        sel_wdata = bus.wdata_in[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (found) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_q     <= '0;
      rdata_q     <= '0;
      r_we        <= 1'b0;
      r_oob       <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_wdata     <= '0;
      last_winner <= IDX_W'(NUM_REQ - 1);
`ifdef PACMAN_PRIORITY_EN
      last_ghost  <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) grant_q[i] <= (win == IDX_W'(i));
          r_we        <= sel_we;
          r_x         <= sel_x;
          r_y         <= sel_y;
          r_wdata     <= sel_wdata;
          r_oob       <= (32'(sel_x) >= MAP_W) || (32'(sel_y) >= MAP_H);
          last_winner <= win;
`ifdef PACMAN_PRIORITY_EN
          if (win != '0) last_ghost <= win;
`endif
        end
        WAIT: if (!r_we) rdata_q <= r_oob ? WALL : bus.ram_rdata;
        DONE: grant_q <= '0;
        default: ;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = (state == DONE) ? grant_q : '0;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.ram_x     = r_x;
  assign bus.ram_y     = r_y;
  assign bus.ram_wdata = r_wdata;
  assign bus.ram_we    = (state == ISSUE) && r_we && !r_oob;
endmodule

// File: doc/map_access_arbiter.md
MAP_ACCESS_ARBITER -- requirements
Module: map_access_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters; index 0 is pacman, 1..NUM_REQ-1 are ghosts.
REQ-002 Parameter MAP_W, default 24, map width in tiles.
REQ-003 Parameter MAP_H, default 24, map height in tiles.
REQ-004 clock  in  1  system clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req  in  NUM_REQ  per-requester access request; held high until that requester's done.
REQ-007 we_in  in  NUM_REQ  per-requester write flag (1 = write, 0 = read).
REQ-008 x_in  in  5*NUM_REQ  per-requester tile x, packed, requester i at bits [5i+4:5i].
REQ-009 y_in  in  5*NUM_REQ  per-requester tile y, packed as x_in.
REQ-010 wdata_in  in  3*NUM_REQ  per-requester sprite code to write, packed.
REQ-011 grant  out  NUM_REQ  one-hot owner of the current transaction.
REQ-012 done  out  NUM_REQ  one-cycle completion pulse to the owner.
REQ-013 rdata  out  3  read sprite code; valid while done is high.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 ram_x, ram_y  out  5 each  map RAM tile address.
REQ-016 ram_we  out  1  map RAM write enable.
REQ-017 ram_wdata  out  3  map RAM write data.
REQ-018 ram_rdata  in  3  map RAM read data; valid one cycle after its address is presented.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE, with transitions IDLE->ISSUE (any req high), ISSUE->WAIT, WAIT->DONE and DONE->IDLE unconditionally.
REQ-020 In IDLE with any req high, the block SHALL select a winner, register its we, x, y and wdata, and set grant one-hot to the winner at the same edge.
REQ-021 Arbitration SHALL be round-robin: the search starts at last_winner+1 modulo NUM_REQ, and last_winner updates on every grant.
REQ-022 grant SHALL be high during ISSUE, WAIT and DONE, and zero in IDLE.
REQ-023 In ISSUE, ram_x and ram_y SHALL present the registered address, and ram_we SHALL equal the registered we; ram_we SHALL be high for exactly this one cycle per write.
REQ-024 In WAIT, a read SHALL capture ram_rdata into rdata; a write SHALL leave rdata unchanged.
REQ-025 In DONE, done[winner] SHALL pulse for one cycle, and all other done bits SHALL be 0.
REQ-026 Every transaction, read or write, SHALL take 4 cycles from the sampling edge to the return to IDLE, giving a request-to-done latency of 3 edges.
REQ-027 A coordinate with x>=MAP_W or y>=MAP_H SHALL suppress ram_we, return rdata=3'b011 (wall), and still complete with done.
REQ-028 If the owner drops req mid-transaction, the transaction SHALL still complete, and done SHALL still pulse.
REQ-029 Requests arriving in any state other than IDLE SHALL wait; no request is lost while it is held high.
REQ-030 Only inputs of the winning requester SHALL affect the RAM; x_in, y_in, wdata_in and we_in changes after the sampling edge SHALL be ignored.

Reset
REQ-031 Reset SHALL force state=IDLE, grant=0, done=0, rdata=0, busy=0, ram_we=0, ram_x=0, ram_y=0, ram_wdata=0, and last_winner=NUM_REQ-1.
REQ-032 Reset asserted mid-transaction SHALL abort it: no write and no done in the next cycle.

Configuration
REQ-033 With macro PACMAN_PRIORITY_EN defined, req[0] SHALL always win when high, and requesters 1..NUM_REQ-1 SHALL round-robin among themselves only when req[0] is low.
REQ-034 Without PACMAN_PRIORITY_EN, all NUM_REQ requesters SHALL share one round-robin ring per REQ-021.

Verification
REQ-035 After reset, assert req=4'b0001 as a read of (3,4) with RAM content 3'b001 -> grant=0001 for 3 cycles, ram_we=0, done[0] pulses 3 edges after sampling, rdata=3'b001.
REQ-036 Issue a write from requester 2 of wdata 3'b000 at (10,10) -> ram_we high exactly one cycle with ram_x=10, ram_y=10 and ram_wdata=0; done[2] pulses.
REQ-037 Hold req=4'b1111 continuously without the macro -> grant order 0,1,2,3,0, with one done per 4 cycles.
REQ-038 Hold req=4'b1111 with PACMAN_PRIORITY_EN defined -> requester 0 wins every transaction, and ghosts never win.
REQ-039 Issue a read at (24,5) -> no RAM write, rdata=3'b011, done pulses on schedule.
REQ-040 Assert reset in the WAIT cycle of a transaction -> next cycle has busy=0, grant=0, done=0, and the next grant goes to requester 0.
